tone_detect_sequencer: RTL and testbench

Controller that sequences the DTMF tone-detector datapath one FFT frame at a time. It waits for the FFT bin buffer to report a full frame, clears the detector, and streams NUM_BINS packed bins into it. It then collects the detector's tone result and debounces it across consecutive frames. Finally it emits one key event per keypress on a valid/ready output toward the I2C/host side.

---
 rtl/tone_detect_sequencer.sv | 176 +++++++++++++++++
 tb/tb_tone_detect_sequencer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_detect_sequencer.sv
// Frame sequencer for the DTMF tone detector: clear, stream bins, collect and debounce the tone, emit keys.
// Define TONE_SEQ_TIMEOUT_EN to bound the wait for det_done by TIMEOUT cycles.
module tone_detect_sequencer #(
   parameter int NUM_BINS     = 64,
   parameter int STABLE_COUNT = 3,
   parameter int TIMEOUT      = 255
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        frame_ready,
   output logic        frame_ack,
   output logic [5:0]  bin_addr,
   input  logic [15:0] bin_data,
   output logic        det_reset_n,
   output logic        det_enable,
   output logic [15:0] det_data,
   input  logic        det_done,
   input  logic [15:0] det_tone,
   output logic        key_valid,
   input  logic        key_ready,
   output logic [15:0] key_code,
   output logic        busy,
   output logic        overrun,
   output logic        det_timeout,
   output logic [2:0]  state_dbg
);

   // Key handshake: a key is transferred on every rising clock edge where key_valid and
   // key_ready are both high; key_code is held stable while key_valid is high.

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CLEAR  = 3'd1,
      S_STREAM = 3'd2,
      S_WAIT   = 3'd3,
      S_EVAL   = 3'd4
   } state_t;

   localparam logic [5:0] LAST_BIN = 6'(NUM_BINS - 1);
   localparam logic [3:0] STAB_TH  = 4'(STABLE_COUNT);

   state_t      state, state_n;
   logic [5:0]  addr_n;
   logic [15:0] result, result_n;
   logic [15:0] last, last_n;
   logic [3:0]  stab, stab_n;
   logic        rep, rep_n;
   logic        issue;
   logic        tmo_hit;

`ifdef TONE_SEQ_TIMEOUT_EN
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
   logic [7:0] wait_cnt;

   // wait_cnt holds the number of WAIT cycles already spent, so the hit lands on the TIMEOUT-th one.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         wait_cnt <= '0;
      else if (state != S_WAIT)
         wait_cnt <= '0;
      else
         wait_cnt <= wait_cnt + 8'd1;
   end

   assign tmo_hit = (wait_cnt == TMO_LAST);
`else
   assign tmo_hit = 1'b0;
`endif

   assign busy      = (state != S_IDLE);
   assign state_dbg = state;

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         state <= S_IDLE;
      else
         state <= state_n;
   end

   always_comb begin
      state_n     = state;
      addr_n      = bin_addr;
      result_n    = result;
      last_n      = last;
      stab_n      = stab;
      rep_n       = rep;
      issue       = 1'b0;
      frame_ack   = 1'b0;
      det_enable  = 1'b0;
      det_data    = '0;
      det_timeout = 1'b0;
      case (state)
         S_IDLE: begin
            if (frame_ready)
               state_n = S_CLEAR;
         end
         S_CLEAR: begin
            addr_n  = '0;
            state_n = S_STREAM;
         end
         S_STREAM: begin
            det_enable = 1'b1;
            det_data   = bin_data;
            addr_n     = bin_addr + 6'd1;
            if (bin_addr == LAST_BIN) begin
               frame_ack = 1'b1;
               addr_n    = '0;
               state_n   = S_WAIT;
            end
         end
         S_WAIT: begin
            // det_done takes priority over a timeout landing on the same cycle.
            if (det_done) begin
               result_n = det_tone;
               state_n  = S_EVAL;
            end else if (tmo_hit) begin
               result_n    = '0;
               det_timeout = 1'b1;
               state_n     = S_EVAL;
            end
         end
         S_EVAL: begin
            if (result == 16'h0000) begin
               last_n = '0;
               stab_n = '0;
               rep_n  = 1'b0;
            end else if (result != last) begin
               last_n = result;
               stab_n = 4'd1;
               rep_n  = 1'b0;
            end else if (stab != 4'hF) begin
               stab_n = stab + 4'd1;
            end
            if ((stab_n >= STAB_TH) && !rep_n) begin
               issue = 1'b1;
               rep_n = 1'b1;
            end
            state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         bin_addr    <= '0;
         result      <= '0;
         last        <= '0;
         stab        <= '0;
         rep         <= 1'b0;
         det_reset_n <= 1'b0;
         key_valid   <= 1'b0;
         key_code    <= '0;
         overrun     <= 1'b0;
      end else begin
         bin_addr    <= addr_n;
         result      <= result_n;
         last        <= last_n;
         stab        <= stab_n;
         rep         <= rep_n;
         det_reset_n <= (state_n != S_CLEAR);
         // A handshake on the same edge frees the slot, so the new key is accepted, not dropped.
         if (issue) begin
            if (key_valid && !key_ready) begin
               overrun <= 1'b1;
            end else begin
               key_code  <= last_n;
               key_valid <= 1'b1;
            end
         end else if (key_valid && key_ready) begin
            key_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_tone_detect_sequencer.sv
// Directed bench for tone_detect_sequencer: frame timing, debounce, re-arm, overrun, reset and timeout.
`timescale 1ns/1ps
module tb_tone_detect_sequencer;

   localparam int NB = 64;
`ifdef TONE_SEQ_TIMEOUT_EN
   localparam int TMO = 10;
`else
   localparam int TMO = 255;
`endif

   logic        clock;
   logic        reset;
   logic        frame_ready;
   logic        frame_ack;
   logic [5:0]  bin_addr;
   logic [15:0] bin_data;
   logic        det_reset_n;
   logic        det_enable;
   logic [15:0] det_data;
   logic        det_done;
   logic [15:0] det_tone;
   logic        key_valid;
   logic        key_ready;
   logic [15:0] key_code;
   logic        busy;
   logic        overrun;
   logic        det_timeout;
   logic [2:0]  state_dbg;

   int          n_checks = 0;
   int          n_pass = 0;
   int          cyc = 0;
   int          keys_seen = 0;
   int          keys_pushed = 0;
   int          tmo_pulses = 0;
   int          exp_tmo = 0;
   int          cur_clear = 0;
   int          prev_clear = 0;
   bit          hold_fr = 1'b0;
   logic [15:0] exp_q[$];
   logic [15:0] mon_exp;

   tone_detect_sequencer #(
      .NUM_BINS(NB),
      .STABLE_COUNT(3),
      .TIMEOUT(TMO)
   ) dut (
      .clock(clock),
      .reset(reset),
      .frame_ready(frame_ready),
      .frame_ack(frame_ack),
      .bin_addr(bin_addr),
      .bin_data(bin_data),
      .det_reset_n(det_reset_n),
      .det_enable(det_enable),
      .det_data(det_data),
      .det_done(det_done),
      .det_tone(det_tone),
      .key_valid(key_valid),
      .key_ready(key_ready),
      .key_code(key_code),
      .busy(busy),
      .overrun(overrun),
      .det_timeout(det_timeout),
      .state_dbg(state_dbg)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   always @(posedge clock) cyc++;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   function automatic logic [15:0] bin_pat(input logic [5:0] a);
      return {2'b10, a, 8'h5A ^ {2'b00, a}};
   endfunction

   assign bin_data = bin_pat(bin_addr);

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // scoreboard: keys are popped as the consumer accepts them
   always @(negedge clock) begin
      if (det_timeout === 1'b1) tmo_pulses++;
      if (key_valid === 1'b1 && key_ready === 1'b1) begin
         if (exp_q.size() > 0) mon_exp = exp_q.pop_front();
         else mon_exp = 16'hxxxx;
         keys_seen++;
         check("key_code", {16'h0, key_code}, {16'h0, mon_exp});
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // One frame from IDLE back to IDLE. wcyc=0 means det_done is never raised (timeout path).
   task automatic run_frame(input logic [15:0] tone, input int wcyc, input bit push, input bit exp_kv);
      int guard;
      int en_cnt;
      int ack_at;
      int ack_cnt;
      int derr;
      int tmo_at;
      en_cnt  = 0;
      ack_at  = -1;
      ack_cnt = 0;
      derr    = 0;
      tmo_at  = -1;
      frame_ready = 1'b1;
      guard = 0;
      while (det_reset_n !== 1'b0 && guard < 8) begin
         step();
         guard++;
      end
      check("clear_busy", {31'h0, busy}, 32'd1);
      prev_clear = cur_clear;
      cur_clear  = cyc;
      frame_ready = hold_fr;
      if (det_enable) en_cnt++;
      step();
      for (int i = 0; i < NB; i++) begin
         if (det_enable) en_cnt++;
         if (bin_addr !== 6'(i) || det_data !== bin_pat(6'(i))) derr++;
         if (frame_ack) begin
            ack_cnt++;
            ack_at = int'(bin_addr);
         end
         step();
      end
      if (wcyc > 0) begin
         for (int k = 1; k <= wcyc; k++) begin
            if (det_enable) en_cnt++;
            if (frame_ack) ack_cnt++;
            if (k == wcyc) begin
               det_done = 1'b1;
               det_tone = tone;
               if (push) begin
                  exp_q.push_back(tone);
                  keys_pushed++;
               end
            end
            step();
         end
      end else begin
         det_tone = tone;
         exp_tmo++;
         for (int k = 1; k <= TMO + 4 && tmo_at < 0; k++) begin
            if (det_enable) en_cnt++;
            if (det_timeout) tmo_at = k;
            step();
         end
         check("timeout_cycle", tmo_at, TMO);
      end
      det_done = 1'b0;
      det_tone = '0;
      if (det_enable) en_cnt++;
      step();
      check("key_valid_after_eval", {31'h0, key_valid}, {31'h0, exp_kv});
      check("idle_busy", {31'h0, busy}, 32'd0);
      check("det_enable_cycles", en_cnt, NB);
      check("frame_ack_bin", ack_at, NB - 1);
      check("frame_ack_count", ack_cnt, 1);
      check("stream_data_errs", derr, 0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int guard;
      reset = 1'b1;
      frame_ready = 1'b0;
      det_done = 1'b0;
      det_tone = '0;
      key_ready = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      check("rst_det_reset_n", {31'h0, det_reset_n}, 32'd0);
      check("rst_flags", {26'h0, frame_ack, det_enable, key_valid, busy, overrun, det_timeout}, 32'd0);
      check("rst_bin_addr", {26'h0, bin_addr}, 32'd0);
      check("rst_det_data", {16'h0, det_data}, 32'd0);
      check("rst_key_code", {16'h0, key_code}, 32'd0);
      reset = 1'b0;
      step();
      check("rel_det_reset_n", {31'h0, det_reset_n}, 32'd1);
      check("rel_busy", {31'h0, busy}, 32'd0);
      step();

      // debounce: key after the third identical frame, none after the fourth
      run_frame(16'h0031, 3, 1'b0, 1'b0);
      run_frame(16'h0031, 3, 1'b0, 1'b0);
      run_frame(16'h0031, 3, 1'b1, 1'b1);
      run_frame(16'h0031, 3, 1'b0, 1'b0);
      repeat (3) step();
      check("no_requeue_busy", {31'h0, busy}, 32'd0);
      check("overrun_clear", {31'h0, overrun}, 32'd0);

      // reset in the middle of STREAM
      frame_ready = 1'b1;
      guard = 0;
      while (!(det_enable === 1'b1 && bin_addr == 6'd20) && guard < 50) begin
         step();
         guard++;
      end
      check("reach_bin20", {26'h0, bin_addr}, 32'd20);
      frame_ready = 1'b0;
      reset = 1'b1;
      #1;
      check("midrst_det_reset_n", {31'h0, det_reset_n}, 32'd0);
      check("midrst_flags", {26'h0, frame_ack, det_enable, key_valid, busy, overrun, det_timeout}, 32'd0);
      check("midrst_bin_addr", {26'h0, bin_addr}, 32'd0);
      check("midrst_det_data", {16'h0, det_data}, 32'd0);
      check("midrst_key_code", {16'h0, key_code}, 32'd0);
      step();
      reset = 1'b0;
      step();
      check("midrel_det_reset_n", {31'h0, det_reset_n}, 32'd1);
      check("midrel_busy", {31'h0, busy}, 32'd0);

      // re-arm through a silent frame
      run_frame(16'h0031, $urandom_range(1, 6), 1'b0, 1'b0);
      run_frame(16'h0031, $urandom_range(1, 6), 1'b0, 1'b0);
      run_frame(16'h0031, $urandom_range(1, 6), 1'b1, 1'b1);
      run_frame(16'h0000, $urandom_range(1, 6), 1'b0, 1'b0);
      run_frame(16'h0031, $urandom_range(1, 6), 1'b0, 1'b0);
      run_frame(16'h0031, $urandom_range(1, 6), 1'b0, 1'b0);
      run_frame(16'h0031, $urandom_range(1, 6), 1'b1, 1'b1);

      // tone change restarts the count
      run_frame(16'h0000, 2, 1'b0, 1'b0);
      run_frame(16'h0031, 2, 1'b0, 1'b0);
      run_frame(16'h0031, 2, 1'b0, 1'b0);
      run_frame(16'h0032, 2, 1'b0, 1'b0);
      run_frame(16'h0032, 2, 1'b0, 1'b0);
      run_frame(16'h0032, 2, 1'b1, 1'b1);

      // back-to-back frames with frame_ready held high
      hold_fr = 1'b1;
      run_frame(16'h0000, 3, 1'b0, 1'b0);
      run_frame(16'h0000, 3, 1'b0, 1'b0);
      check("frame_period", cur_clear - prev_clear, 70);
      hold_fr = 1'b0;
      frame_ready = 1'b0;
      step();

      // overrun: consumer stalled while a second key debounces
      check("overrun_pre", {31'h0, overrun}, 32'd0);
      key_ready = 1'b0;
      run_frame(16'h0041, 2, 1'b0, 1'b0);
      run_frame(16'h0041, 2, 1'b0, 1'b0);
      run_frame(16'h0041, 2, 1'b1, 1'b1);
      run_frame(16'h0042, 2, 1'b0, 1'b1);
      run_frame(16'h0042, 2, 1'b0, 1'b1);
      run_frame(16'h0042, 2, 1'b0, 1'b1);
      check("overrun_code_held", {16'h0, key_code}, 32'h0041);
      check("overrun_set", {31'h0, overrun}, 32'd1);
      key_ready = 1'b1;
      step();
      step();
      check("overrun_drained", {31'h0, key_valid}, 32'd0);
      run_frame(16'h0000, 2, 1'b0, 1'b0);
      check("overrun_sticky", {31'h0, overrun}, 32'd1);

`ifdef TONE_SEQ_TIMEOUT_EN
      // timeout acts as a silent frame
      run_frame(16'h0051, 2, 1'b0, 1'b0);
      run_frame(16'h0051, 2, 1'b0, 1'b0);
      run_frame(16'h0051, 0, 1'b0, 1'b0);
      run_frame(16'h0051, 2, 1'b0, 1'b0);
      run_frame(16'h0051, 2, 1'b0, 1'b0);
      run_frame(16'h0051, 2, 1'b1, 1'b1);
`endif

      repeat (5) step();
      check("queue_empty", exp_q.size(), 0);
      check("keys_seen", keys_seen, keys_pushed);
      check("timeout_pulses", tmo_pulses, exp_tmo);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
